data_sram_bridge: RTL and testbench
===================================

Name: data_sram_bridge

Overview:
- Sits directly downstream of the core's memory stage, between the core's single-cycle data-memory port and the SoC's split-handshake SRAM-like data bus.
- Inputs from the core: enable, byte write-enables, address, write data.
- Converts each core access into one bus transaction (request / addr_ok / data_ok).
- Stalls the core until the transaction completes, then returns read data.
- Holds completed results while other pipeline stalls keep the memory stage frozen, so no access is ever issued twice.

Parameters:
- ADDR_W, 32, address width of core and bus.
- DATA_W, 32, data width; fixed at 32, with 4 byte lanes.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- cpu_en  input  1  memory-stage data access valid.
- cpu_wen  input  4  byte write enables; 0000 means read.
- cpu_addr  input  ADDR_W  byte address.
- cpu_wdata  input  DATA_W  store data, already lane-aligned.
- cpu_longest_stall  input  1  OR of every other stall source holding the memory stage.
- cpu_stall  output  1  bridge stall request to the hazard unit.
- cpu_rdata  output  DATA_W  read data of the last completed read.
- bus_req  output  1  bus request valid.
- bus_wr  output  1  1 = write, 0 = read.
- bus_size  output  2  0 = byte, 1 = half, 2 = word.
- bus_addr  output  ADDR_W  request address.
- bus_wstrb  output  4  write byte strobes.
- bus_wdata  output  DATA_W  write data.
- bus_addr_ok  input  1  request accepted this cycle.
- bus_data_ok  input  1  response (read data or write ack) valid this cycle.
- bus_rdata  input  DATA_W  read response data.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE.
  - bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata and cpu_rdata all 0.
  - Reset mid-transaction abandons it: bus_req=0 from the next cycle, and a late bus_data_ok is ignored. The bus slave shares the same rst.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If cpu_en=1, capture the request into registers and go to REQ.
  - Captured values: bus_wr=|cpu_wen; bus_wstrb=cpu_wen; bus_wdata=cpu_wdata.
  - Reads: bus_size=2, bus_addr={cpu_addr[31:2],2'b00}.
  - Writes:
    - wen 0001/0010/0100/1000 -> size 0, addr=cpu_addr.
    - 0011/1100 -> size 1, addr={cpu_addr[31:1],1'b0}.
    - Any other nonzero pattern -> size 2, word-aligned addr.
- REQ: bus_req=1, with all fields stable from registers.
  - bus_addr_ok=1 and bus_data_ok=0 -> WAIT.
  - bus_addr_ok=1 and bus_data_ok=1 in the same cycle -> complete immediately, go to DONE.
  - bus_data_ok without bus_addr_ok is a protocol violation and is ignored.
- WAIT: bus_req=0. On bus_data_ok=1 -> DONE. If the access is a read, capture bus_rdata into cpu_rdata.
- DONE:
  - cpu_rdata is valid.
  - cpu_longest_stall=1 -> stay in DONE; no new request is issued even though cpu_en is still high.
  - cpu_longest_stall=0 -> IDLE. The core advances on this edge.
- cpu_stall is combinational: (IDLE & cpu_en) | REQ | WAIT. It is 0 in DONE, and in IDLE when cpu_en=0.
- cpu_rdata holds its value across writes and idle cycles. It changes only on read completion or reset.
- Latency: with zero-wait bus (addr_ok in the first REQ cycle, data_ok the next), cpu_stall is high for 3 cycles (IDLE, REQ, WAIT), and data is available in the 4th.
- Back-to-back accesses: DONE->IDLE takes one cycle. The next access is sampled in IDLE on the following cycle.
- The core must keep cpu_* stable while cpu_stall=1. The bridge samples them only in IDLE.
- One outstanding transaction maximum.

Test Plan:
- Read, zero-wait: rst 2 cycles; cpu_en=1, wen=0000, addr=0x1FC0_0006; slave gives addr_ok in REQ cycle 1, data_ok next with rdata=0xCAFE_F00D -> bus_addr=0x1FC0_0004, size=2, wr=0; cpu_stall high exactly 3 cycles; cpu_rdata=0xCAFEF00D in DONE.
- Byte store: wen=0100, addr=0x8000_0012, wdata=0x00AB_0000 -> bus_wr=1, size=0, addr=0x80000012, wstrb=0100; cpu_rdata unchanged.
- Half/word stores: wen=1100 at addr 0x...03 -> size 1, addr low bits 10; wen=1111 -> size 2.
- Slow slave: addr_ok delayed 4 cycles and data_ok a further 5 cycles -> bus_req high exactly until the addr_ok cycle; fields stable throughout; cpu_stall high until DONE.
- Held completion: complete a read with cpu_longest_stall=1 for 6 cycles and cpu_en kept high -> state stays DONE; bus_req never reasserted; cpu_stall=0; cpu_rdata stable. Release -> IDLE.
- Simultaneous accept: addr_ok and data_ok in the same REQ cycle -> direct REQ->DONE. Then reset asserted during a later WAIT -> state IDLE, outputs 0, and the late data_ok is ignored.

Source files
------------

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: converts the core's single-cycle data-memory access into
// one request / addr_ok / data_ok transaction on the SRAM-like bus. The core
// is stalled until the response arrives. The completed result is then held
// while the rest of the pipeline keeps the memory stage frozen, so no access
// is issued twice.
module data_sram_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_en,
   input  logic [3:0]        cpu_wen,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_longest_stall,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [1:0]        bus_size,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_wstrb,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_addr_ok,
   input  logic              bus_data_ok,
   input  logic [DATA_W-1:0] bus_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,  // waiting for a core access
      ST_REQ  = 2'd1,  // request on the bus, waiting for addr_ok
      ST_WAIT = 2'd2,  // request accepted, waiting for data_ok
      ST_DONE = 2'd3   // result ready, waiting for the pipeline to advance
   } state_t;

   state_t              state_q,     state_d;
   logic                bus_req_q,   bus_req_d;
   logic                bus_wr_q,    bus_wr_d;
   logic [1:0]          bus_size_q,  bus_size_d;
   logic [ADDR_W-1:0]   bus_addr_q,  bus_addr_d;
   logic [3:0]          bus_wstrb_q, bus_wstrb_d;
   logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;

   logic [1:0]          req_size;
   logic [ADDR_W-1:0]   req_addr;

   // Derive transfer size and aligned address from the byte-enable pattern.
   always_comb begin
      // NOTE: every signal written in an always_comb gets a default first;
      // a path that leaves one unassigned would infer a latch.
      req_size = 2'd2;
      req_addr = {cpu_addr[ADDR_W-1:2], 2'b00};
      case (cpu_wen)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
            req_size = 2'd0;
            req_addr = cpu_addr;
         end
         4'b0011, 4'b1100: begin
            req_size = 2'd1;
            req_addr = {cpu_addr[ADDR_W-1:1], 1'b0};
         end
         default: begin
            // reads and all other write patterns stay as word accesses
         end
      endcase
   end

   // Next-state and next-output computation for the transaction FSM.
   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_wr_d    = bus_wr_q;
      bus_size_d  = bus_size_q;
      bus_addr_d  = bus_addr_q;
      bus_wstrb_d = bus_wstrb_q;
      bus_wdata_d = bus_wdata_q;
      cpu_rdata_d = cpu_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (cpu_en) begin
               state_d     = ST_REQ;
               bus_req_d   = 1'b1;
               bus_wr_d    = |cpu_wen;
               bus_size_d  = req_size;
               bus_addr_d  = req_addr;
               bus_wstrb_d = cpu_wen;
               bus_wdata_d = cpu_wdata;
            end
         end
         ST_REQ: begin
            // data_ok without addr_ok is a protocol violation and is ignored
            if (bus_addr_ok) begin
               bus_req_d = 1'b0;
               if (bus_data_ok) begin
                  state_d = ST_DONE;
                  if (!bus_wr_q) begin
                     cpu_rdata_d = bus_rdata;
                  end
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (bus_data_ok) begin
               state_d = ST_DONE;
               if (!bus_wr_q) begin
                  cpu_rdata_d = bus_rdata;
               end
            end
         end
         ST_DONE: begin
            // the core advances on the edge that leaves DONE
            if (!cpu_longest_stall) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered bus/core outputs with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q     <= ST_IDLE;
         bus_req_q   <= 1'b0;
         bus_wr_q    <= 1'b0;
         bus_size_q  <= 2'd0;
         bus_addr_q  <= '0;
         bus_wstrb_q <= 4'd0;
         bus_wdata_q <= '0;
         cpu_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_wr_q    <= bus_wr_d;
         bus_size_q  <= bus_size_d;
         bus_addr_q  <= bus_addr_d;
         bus_wstrb_q <= bus_wstrb_d;
         bus_wdata_q <= bus_wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

   // Stall is combinational so the core freezes in the cycle it presents an access.
   assign cpu_stall = ((state_q == ST_IDLE) && cpu_en) ||
                      (state_q == ST_REQ) || (state_q == ST_WAIT);

   assign bus_req   = bus_req_q;
   assign bus_wr    = bus_wr_q;
   assign bus_size  = bus_size_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wstrb = bus_wstrb_q;
   assign bus_wdata = bus_wdata_q;
   assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge: directed vector table, hand-written
// reset-during-WAIT sequence and randomized accesses against a reference model.
module tb_data_sram_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_en;
   logic [3:0]  cpu_wen;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_longest_stall;
   logic        cpu_stall;
   logic [31:0] cpu_rdata;
   logic        bus_req;
   logic        bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_rdata;

   typedef struct {
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;     // slave response data at data_ok
      int          addr_dly;  // REQ cycles before the addr_ok cycle
      int          data_dly;  // WAIT cycles before the data_ok cycle
      bit          same;      // addr_ok and data_ok in the same cycle
      int          hold;      // DONE cycles held by cpu_longest_stall
      logic        exp_wr;
      logic [1:0]  exp_size;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t tbl [10];

   data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .cpu_en            (cpu_en),
      .cpu_wen           (cpu_wen),
      .cpu_addr          (cpu_addr),
      .cpu_wdata         (cpu_wdata),
      .cpu_longest_stall (cpu_longest_stall),
      .cpu_stall         (cpu_stall),
      .cpu_rdata         (cpu_rdata),
      .bus_req           (bus_req),
      .bus_wr            (bus_wr),
      .bus_size          (bus_size),
      .bus_addr          (bus_addr),
      .bus_wstrb         (bus_wstrb),
      .bus_wdata         (bus_wdata),
      .bus_addr_ok       (bus_addr_ok),
      .bus_data_ok       (bus_data_ok),
      .bus_rdata         (bus_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, got running, expected finished");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference rules: reads are word accesses; one enabled lane is a byte;
   // an aligned lane pair is a half; anything else is a word.
   function automatic void model_fields(input logic [3:0] wen, input logic [31:0] addr,
                                        output logic wr, output logic [1:0] size,
                                        output logic [31:0] a);
      wr = (wen != 4'd0);
      if (!wr) begin
         size = 2'd2; a = addr & ~32'h3;
      end else if ($countones(wen) == 1) begin
         size = 2'd0; a = addr;
      end else if (wen == 4'b0011 || wen == 4'b1100) begin
         size = 2'd1; a = addr & ~32'h1;
      end else begin
         size = 2'd2; a = addr & ~32'h3;
      end
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_req"},   bus_req,   0);
      check({tag, "_wr"},    bus_wr,    0);
      check({tag, "_size"},  bus_size,  0);
      check({tag, "_addr"},  bus_addr,  0);
      check({tag, "_wstrb"}, bus_wstrb, 0);
      check({tag, "_wdata"}, bus_wdata, 0);
      check({tag, "_rdata"}, cpu_rdata, 0);
   endtask

   // One complete access: IDLE, REQ cycles, WAIT cycles, DONE hold, release.
   task automatic run_txn(input vec_t v);
      int stalls = 0;
      int exp_stalls;
      exp_stalls = 1 + (v.addr_dly + 1) + (v.same ? 0 : v.data_dly + 1);

      @(negedge clk);
      cpu_en = 1'b1; cpu_wen = v.wen; cpu_addr = v.addr; cpu_wdata = v.wdata;
      cpu_longest_stall = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      #1;
      check("idle_bus_req", bus_req, 0);
      if (cpu_stall) stalls++;

      for (int i = 0; i <= v.addr_dly; i++) begin
         @(negedge clk);
         bus_addr_ok = (i == v.addr_dly);
         bus_data_ok = v.same && (i == v.addr_dly);
         bus_rdata   = (v.same && i == v.addr_dly) ? v.rdata : $urandom;
         #1;
         check("req_bus_req", bus_req,   1);
         check("req_wr",      bus_wr,    v.exp_wr);
         check("req_size",    bus_size,  v.exp_size);
         check("req_addr",    bus_addr,  v.exp_addr);
         check("req_wstrb",   bus_wstrb, v.wen);
         check("req_wdata",   bus_wdata, v.wdata);
         if (cpu_stall) stalls++;
      end

      if (!v.same) begin
         for (int j = 0; j <= v.data_dly; j++) begin
            @(negedge clk);
            bus_addr_ok = 1'b0;
            bus_data_ok = (j == v.data_dly);
            bus_rdata   = (j == v.data_dly) ? v.rdata : $urandom;
            #1;
            check("wait_bus_req", bus_req, 0);
            if (cpu_stall) stalls++;
         end
      end

      if (v.wen == 4'd0) model_rdata = v.rdata;

      // cpu_en stays high throughout DONE; the bridge must not reissue
      for (int h = 0; h <= v.hold; h++) begin
         @(negedge clk);
         bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = $urandom;
         cpu_longest_stall = (h < v.hold);
         #1;
         check("done_stall",   cpu_stall, 0);
         check("done_bus_req", bus_req,   0);
         check("done_rdata",   cpu_rdata, model_rdata);
      end
      check("stall_cycles", stalls, exp_stalls);

      @(negedge clk);
      cpu_en = 1'b0; cpu_longest_stall = 1'b0;
      #1;
      check("post_stall",   cpu_stall, 0);
      check("post_bus_req", bus_req,   0);
      check("post_rdata",   cpu_rdata, model_rdata);
   endtask

   initial begin
      vec_t rv;
      tbl[0] = '{4'b0000, 32'h1FC0_0006, 32'h0000_0000, 32'hCAFE_F00D, 0, 0, 1'b0, 0, 1'b0, 2'd2, 32'h1FC0_0004};
      tbl[1] = '{4'b0100, 32'h8000_0012, 32'h00AB_0000, 32'h1111_1111, 0, 0, 1'b0, 0, 1'b1, 2'd0, 32'h8000_0012};
      tbl[2] = '{4'b1100, 32'h8000_0003, 32'hBEEF_0000, 32'h2222_2222, 0, 1, 1'b0, 0, 1'b1, 2'd1, 32'h8000_0002};
      tbl[3] = '{4'b1111, 32'h8000_0007, 32'h0123_4567, 32'h3333_3333, 1, 0, 1'b0, 1, 1'b1, 2'd2, 32'h8000_0004};
      tbl[4] = '{4'b0000, 32'h0000_1003, 32'h0000_0000, 32'h1234_5678, 4, 5, 1'b0, 0, 1'b0, 2'd2, 32'h0000_1000};
      tbl[5] = '{4'b0000, 32'h0000_0041, 32'h0000_0000, 32'h0BAD_BEEF, 0, 0, 1'b0, 6, 1'b0, 2'd2, 32'h0000_0040};
      tbl[6] = '{4'b0000, 32'h0000_0012, 32'h0000_0000, 32'hA5A5_A5A5, 0, 0, 1'b1, 0, 1'b0, 2'd2, 32'h0000_0010};
      tbl[7] = '{4'b0011, 32'h0000_0101, 32'h0000_5A5A, 32'h4444_4444, 1, 0, 1'b1, 0, 1'b1, 2'd1, 32'h0000_0100};
      tbl[8] = '{4'b0101, 32'h0000_0203, 32'h00FF_00FF, 32'h5555_5555, 0, 2, 1'b0, 1, 1'b1, 2'd2, 32'h0000_0200};
      tbl[9] = '{4'b0001, 32'h0000_0003, 32'h0000_0077, 32'h6666_6666, 2, 0, 1'b0, 0, 1'b1, 2'd0, 32'h0000_0003};

      rst = 1'b1; cpu_en = 1'b0; cpu_wen = 4'd0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
      cpu_longest_stall = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
      model_rdata = 32'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check_all_zero("reset");
      check("reset_stall", cpu_stall, 0);

      // Directed vectors
      for (int k = 0; k < 10; k++) run_txn(tbl[k]);

      // Reset while in WAIT abandons the access; a late data_ok is ignored
      @(negedge clk);
      cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h0000_0020;
      #1;
      check("rstw_idle_stall", cpu_stall, 1);
      @(negedge clk);
      bus_addr_ok = 1'b1;
      #1;
      check("rstw_req", bus_req, 1);
      @(negedge clk);
      bus_addr_ok = 1'b0; rst = 1'b1;
      #1;
      check("rstw_wait_stall", cpu_stall, 1);
      check("rstw_wait_req",   bus_req,   0);
      @(negedge clk);
      rst = 1'b0; cpu_en = 1'b0;
      #1;
      model_rdata = 32'd0;
      check_all_zero("rstw");
      check("rstw_stall", cpu_stall, 0);
      @(negedge clk);
      bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      #1;
      check("late_ok_stall", cpu_stall, 0);
      @(negedge clk);
      bus_data_ok = 1'b0;
      #1;
      check("late_ok_rdata", cpu_rdata, 0);
      check("late_ok_req",   bus_req,   0);
      check("late_ok_stall2", cpu_stall, 0);
      run_txn(tbl[0]);

      // Randomized accesses against the reference model
      for (int n = 0; n < 60; n++) begin
         rv.wen      = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         rv.addr     = $urandom;
         rv.wdata    = $urandom;
         rv.rdata    = $urandom;
         rv.addr_dly = $urandom_range(0, 3);
         rv.data_dly = $urandom_range(0, 3);
         rv.same     = ($urandom_range(0, 3) == 0);
         rv.hold     = $urandom_range(0, 2);
         model_fields(rv.wen, rv.addr, rv.exp_wr, rv.exp_size, rv.exp_addr);
         run_txn(rv);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
